// File: rtl/adder_ahead_seq_pkg.sv
// Shared definitions for the sequenced lookahead adder: FSM encoding and
// the chunk-index width helper.
package adder_ahead_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/adder_ahead_chunk.sv
// CHUNK-bit combinational lookahead slice built from per-bit generate and
// propagate cells; also exposes the carry into its MSB for overflow detection.
module adder_ahead_chunk
    import adder_ahead_seq_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK-1:0] gen;
    logic [CHUNK-1:0] prop;
    logic             carry;

    assign gen  = a_i & b_i;
    assign prop = a_i | b_i;

    // A scalar running carry keeps the chain free of self-referencing vectors.
    always_comb begin
        sum_o  = '0;
        cmsb_o = 1'b0;
        carry  = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            if (i == CHUNK - 1) cmsb_o = carry;
            carry = gen[i] | (prop[i] & carry);
        end
        cout_o = carry;
    end

endmodule

// File: rtl/adder_ahead_seq.sv
// Multi-cycle WIDTH-bit adder that walks one CHUNK-bit lookahead slice across
// the held operands, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | ready for a request; result registers hold the last answer
// RUN   | adding chunk idx_q each cycle, inter-chunk carry in carry_q
// DONE  | result valid, held until the consumer takes it
module adder_ahead_seq
    import adder_ahead_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK > WIDTH) begin : g_bad_params
        $error("adder_ahead_seq: WIDTH must be a positive multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;

    assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
    assign slice_b = b_q[idx_q*CHUNK +: CHUNK];

    adder_ahead_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout),
        .cmsb_o (slice_cmsb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // Carry into the top chunk's MSB is the carry into bit WIDTH-1.
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = (state_q == S_RUN) || (state_q == S_DONE);
    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign ovf_o   = ovf_q;

endmodule
